// File: rtl/wall_rect_collider_if.sv
// rtl/wall_rect_collider_if.sv - table write, query and response bundle for the wall collider
interface wall_rect_collider_if #(
  parameter int COORD_W   = 10,
  parameter int SIZE_W    = 6,
  parameter int NUM_RECTS = 16,
  parameter int IDX_W     = $clog2(NUM_RECTS)
);
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_enable;
  logic [COORD_W-1:0] wr_xmin;
  logic [COORD_W-1:0] wr_xmax;
  logic [COORD_W-1:0] wr_ymin;
  logic [COORD_W-1:0] wr_ymax;

  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [SIZE_W-1:0]  req_w;
  logic [SIZE_W-1:0]  req_h;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic [IDX_W-1:0]   resp_idx;

  modport master (
    output wr_en, wr_idx, wr_enable, wr_xmin, wr_xmax, wr_ymin, wr_ymax,
    output req_valid, req_x, req_y, req_w, req_h, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_idx
  );

  modport slave (
    input  wr_en, wr_idx, wr_enable, wr_xmin, wr_xmax, wr_ymin, wr_ymax,
    input  req_valid, req_x, req_y, req_w, req_h, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_idx
  );
endinterface

// File: rtl/wall_rect_collider.sv
// rtl/wall_rect_collider.sv - sequential actor-box vs wall-table collision engine
// Scans one table entry per clock; the lowest-index overlapping enabled entry wins.
module wall_rect_collider #(
  parameter int COORD_W   = 10,
  parameter int SIZE_W    = 6,
  parameter int NUM_RECTS = 16,
  parameter int IDX_W     = $clog2(NUM_RECTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wall_rect_collider_if.slave  bus
);
  localparam int CW1 = COORD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [IDX_W-1:0]   r_resp_idx;
  logic [IDX_W-1:0]   r_idx;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [SIZE_W-1:0]  r_w;
  logic [SIZE_W-1:0]  r_h;

  logic [NUM_RECTS-1:0] r_en;
  logic [COORD_W-1:0]   r_xmin [NUM_RECTS];
  logic [COORD_W-1:0]   r_xmax [NUM_RECTS];
  logic [COORD_W-1:0]   r_ymin [NUM_RECTS];
  logic [COORD_W-1:0]   r_ymax [NUM_RECTS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en <= '0;
    end else if (bus.wr_en) begin
      r_en[bus.wr_idx] <= bus.wr_enable;
    end
  end

  // Bounds carry no reset: a disabled entry's bounds are never consulted.
  always_ff @(posedge i_clk) begin
    if (!i_rst && bus.wr_en) begin
      r_xmin[bus.wr_idx] <= bus.wr_xmin;
      r_xmax[bus.wr_idx] <= bus.wr_xmax;
      r_ymin[bus.wr_idx] <= bus.wr_ymin;
      r_ymax[bus.wr_idx] <= bus.wr_ymax;
    end
  end

  logic [CW1-1:0] w_x0, w_y0, w_x_end, w_y_end;
  logic [CW1-1:0] w_xlo, w_ylo, w_xhi, w_yhi;
  logic           w_empty;
  logic           w_hit;

  // One extra bit on every sum keeps box ends and bound+1 from wrapping.
  assign w_x0    = {1'b0, r_x};
  assign w_y0    = {1'b0, r_y};
  assign w_x_end = w_x0 + {{(CW1-SIZE_W){1'b0}}, r_w};
  assign w_y_end = w_y0 + {{(CW1-SIZE_W){1'b0}}, r_h};
  assign w_xlo   = {1'b0, r_xmin[r_idx]} + CW1'(1);
  assign w_ylo   = {1'b0, r_ymin[r_idx]} + CW1'(1);
  assign w_xhi   = {1'b0, r_xmax[r_idx]};
  assign w_yhi   = {1'b0, r_ymax[r_idx]};
  assign w_empty = (w_xhi <= w_xlo) || (w_yhi <= w_ylo);
  assign w_hit   = r_en[r_idx] && (r_w != '0) && (r_h != '0) && !w_empty &&
                   (w_x0 < w_xhi) && (w_x_end > w_xlo) &&
                   (w_y0 < w_yhi) && (w_y_end > w_ylo);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_x         <= bus.req_x;
            r_y         <= bus.req_y;
            r_w         <= bus.req_w;
            r_h         <= bus.req_h;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_resp_hit   <= 1'b1;
            r_resp_idx   <= r_idx;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (r_idx == LAST_IDX) begin
            r_resp_hit   <= 1'b0;
            r_resp_idx   <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_idx   = r_resp_idx;
endmodule
